// File: rtl/tx_frame_pkg.sv
// Shared definitions for the tx frame scheduler slice.
// Contents: FSM state encoding, default SYNC byte, ID field width,
// frame overhead byte count and a byte-state helper.
// Optional feature macro: TX_FRAME_CHECKSUM_EN (adds the checksum byte).
package tx_frame_pkg;

  localparam int         ID_W         = 3;      // requester index width in the ID byte
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

`ifdef TX_FRAME_CHECKSUM_EN
  localparam int FRAME_OVERHEAD = 4;            // SYNC, ID, LEN, CSUM
`else
  localparam int FRAME_OVERHEAD = 3;            // SYNC, ID, LEN
`endif

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_ARB  = 4'd1,
    S_SYNC = 4'd2,
    S_ID   = 4'd3,
    S_LEN  = 4'd4,
    S_PAY  = 4'd5,
    S_CSUM = 4'd6,
    S_GAP  = 4'd7,
    S_DONE = 4'd8
  } state_t;

  // States in which a byte is on the wire (tx_enable_signal high).
  function automatic logic is_byte_state(input state_t s);
    return (s == S_SYNC) || (s == S_ID) || (s == S_LEN) || (s == S_PAY) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Requester bus plus tx_uart byte link of the frame scheduler.
//   req_valid/req_len/req_data  : per-requester frame offer (len, data are 8 bits per lane)
//   req_data_ready/grant        : pop strobe and one-hot frame owner
//   tx_enable_signal/tx_data    : byte launch towards tx_uart
//   tx_done_signal              : end-of-byte pulse from tx_uart
// slave modport = scheduler side, master modport = requesters + tx_uart side.
interface tx_frame_scheduler_if #(parameter int N_REQ = 2) ();
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0][7:0]  req_len;
  logic [N_REQ-1:0][7:0]  req_data;
  logic [N_REQ-1:0]       req_data_ready;
  logic [N_REQ-1:0]       grant;
  logic                   tx_enable_signal;
  logic [7:0]             tx_data;
  logic                   tx_done_signal;

  modport slave (
    input  req_valid, req_len, req_data, tx_done_signal,
    output req_data_ready, grant, tx_enable_signal, tx_data
  );

  modport master (
    output req_valid, req_len, req_data, tx_done_signal,
    input  req_data_ready, grant, tx_enable_signal, tx_data
  );
endinterface

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from rr_ptr upward (wrapping) for the first
// requester and reports it combinationally; the pointer moves past the
// winner only on an en strobe with a valid winner.
//   clk, rst (async active-low), en : strobe that commits the grant
//   req                             : request vector
//   gnt / idx / found               : one-hot winner, its index, any winner
module rr_arbiter
  import tx_frame_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  logic [ID_W-1:0] rr_ptr;

  // k is the distance from rr_ptr; the first hit in k order wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int k = 0; k < N_REQ; k++)
      for (int j = 0; j < N_REQ; j++)
        if (!found && req[j] && (((int'(rr_ptr) + k) % N_REQ) == j)) begin
          found  = 1'b1;
          idx    = ID_W'(j);
          gnt[j] = 1'b1;
        end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr <= '0;
    else if (en && found)
      rr_ptr <= (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares one tx_uart among N_REQ frame requesters. Each granted frame goes
// out as SYNC, ID, LEN, payload[LEN] (+ checksum when TX_FRAME_CHECKSUM_EN
// is defined), with GAP_CYC idle clocks after every byte except the last.
//   clk, rst (async active-low)
//   bus (slave)  : requester bus and tx_uart enable/data/done link
//   busy         : frame owned, from grant through frame_done
//   frame_done   : one-cycle pulse after the last byte's tx_done_signal
module tx_frame_scheduler
  import tx_frame_pkg::*;
#(
  parameter int         N_REQ     = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         GAP_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_frame_scheduler_if.slave  bus,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int GW = $clog2(GAP_CYC + 1);

`ifdef TX_FRAME_CHECKSUM_EN
  localparam state_t LAST_ST = S_CSUM;
`else
  localparam state_t LAST_ST = S_DONE;
`endif

  state_t           state, nxt_st, follow, after_q;
  logic [N_REQ-1:0] grant_q, arb_gnt;
  logic [ID_W-1:0]  win_q, arb_idx;
  logic             arb_found, launch_q;
  logic [7:0]       len_q, cnt_q, byte_q, cur_byte, sel_data, arb_len;
  logic [GW-1:0]    gap_q;
`ifdef TX_FRAME_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == S_ARB),
    .req   (bus.req_valid),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // Lane muxes: winner's live payload byte and the arbitration winner's length.
  always_comb begin
    sel_data = '0;
    arb_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == ID_W'(i))   sel_data = bus.req_data[i];
      if (arb_idx == ID_W'(i)) arb_len  = bus.req_len[i];
    end
  end

  // Byte that follows the current one. cnt_q still holds the count
  // including the byte in flight, so 1 means this is the last payload byte.
  always_comb begin
    follow = S_DONE;
    case (state)
      S_SYNC:  follow = S_ID;
      S_ID:    follow = S_LEN;
      S_LEN:   follow = (len_q != 8'd0) ? S_PAY : LAST_ST;
      S_PAY:   follow = (cnt_q != 8'd1) ? S_PAY : LAST_ST;
      default: follow = S_DONE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt_st;
  end

  // Next state; tx_done_signal only counts while a byte is on the wire.
  always_comb begin
    nxt_st = state;
    case (state)
      S_IDLE: if (|bus.req_valid) nxt_st = S_ARB;
      S_ARB:  nxt_st = arb_found ? S_SYNC : S_IDLE;
      S_GAP:  if (gap_q == '0) nxt_st = after_q;
      S_DONE: nxt_st = S_IDLE;
      default:
        if (is_byte_state(state) && bus.tx_done_signal)
          nxt_st = (follow == S_DONE) ? S_DONE : S_GAP;
    endcase
  end

  // Frame datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q  <= '0;
      win_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      launch_q <= 1'b0;
      gap_q    <= '0;
      after_q  <= S_IDLE;
`ifdef TX_FRAME_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      launch_q <= is_byte_state(nxt_st) && (nxt_st != state);
      // Freeze the launched byte; PAY's source may move on after the pop.
      if (launch_q) byte_q <= cur_byte;
      if (state == S_ARB && arb_found) begin
        grant_q <= arb_gnt;
        win_q   <= arb_idx;
        len_q   <= arb_len;
        cnt_q   <= arb_len;
      end else if (state == S_DONE) begin
        grant_q <= '0;
      end
      if (nxt_st == S_GAP && state != S_GAP) begin
        gap_q   <= GW'(GAP_CYC - 1);
        after_q <= follow;
      end else if (state == S_GAP && gap_q != '0) begin
        gap_q   <= gap_q - 1'b1;
      end
      if (state == S_PAY && bus.tx_done_signal) cnt_q <= cnt_q - 8'd1;
`ifdef TX_FRAME_CHECKSUM_EN
      if (state == S_ARB)
        csum_q <= '0;
      else if (launch_q && (state == S_ID || state == S_LEN || state == S_PAY))
        csum_q <= csum_q + cur_byte;
`endif
    end
  end

  // Outputs
  always_comb begin
    cur_byte = '0;
    case (state)
      S_SYNC: cur_byte = SYNC_BYTE;
      S_ID:   cur_byte = 8'(win_q);
      S_LEN:  cur_byte = len_q;
      S_PAY:  cur_byte = sel_data;
`ifdef TX_FRAME_CHECKSUM_EN
      S_CSUM: cur_byte = csum_q;
`endif
      default: cur_byte = '0;
    endcase
    bus.tx_enable_signal = is_byte_state(state);
    bus.tx_data          = !is_byte_state(state) ? 8'd0 : (launch_q ? cur_byte : byte_q);
    bus.req_data_ready   = (state == S_PAY && launch_q) ? grant_q : '0;
    bus.grant            = grant_q;
    busy                 = |grant_q;
    frame_done           = (state == S_DONE);
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
module tb_tx_frame_scheduler;
  import tx_frame_pkg::*;

  localparam int N   = 2;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, frame_done;

  always #5 clk = ~clk;

  tx_frame_scheduler_if #(.N_REQ(N)) bus ();

  tx_frame_scheduler #(.N_REQ(N), .SYNC_BYTE(8'hA5), .GAP_CYC(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   pay [N][$];      // payload each requester offers
  int           idx [N];         // next payload byte presented
  int           pops [N];        // req_data_ready pulses seen
  logic [N-1:0] pend = '0;
  logic [7:0]   got_q [$];       // bytes seen on the tx link
  logic [7:0]   exp_q [$];
  logic [N-1:0] gnt_log [$];
  int           fd_cnt = 0;
  int           model_ptr = 0;
  bit           stray_en = 1'b0;
  int           bt = 0, lim = 2;
  logic         prev_en = 1'b0;
  bit           in_frame = 1'b0;
  int           low_cnt = 0;
  logic [7:0]   cur_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requesters advance after a pop; tx_uart model answers each byte after 1..4 extra clocks.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (pend[i]) idx[i]++;
    pend = '0;
    for (int i = 0; i < N; i++)
      bus.req_data[i] = (idx[i] < pay[i].size()) ? pay[i][idx[i]] : 8'h00;
    bus.tx_done_signal = 1'b0;
    if (bus.tx_enable_signal) begin
      if (bt >= lim) begin
        bus.tx_done_signal = 1'b1;
        bt  = 0;
        lim = $urandom_range(1, 4);
      end else bt++;
    end else begin
      bt = 0;
      if (stray_en && $urandom_range(0, 3) == 0) bus.tx_done_signal = 1'b1;
    end
  end

  // Link monitor
  always @(negedge clk) begin
    if (!rst) begin
      prev_en  = 1'b0;
      in_frame = 1'b0;
      low_cnt  = 0;
    end else begin
      if (bus.tx_enable_signal && !prev_en) begin
        if (in_frame) chk("gap_len", 32'(low_cnt), 32'(GAP));
        in_frame = 1'b1;
        cur_b    = bus.tx_data;
        got_q.push_back(bus.tx_data);
      end
      if (bus.tx_enable_signal && bus.tx_done_signal)
        chk("tx_data_hold", 32'(bus.tx_data), 32'(cur_b));
      low_cnt = bus.tx_enable_signal ? 0 : low_cnt + 1;
      for (int i = 0; i < N; i++)
        if (bus.req_data_ready[i]) begin
          pend[i] = 1'b1;
          pops[i]++;
        end
      if (frame_done) begin
        fd_cnt++;
        gnt_log.push_back(bus.grant);
        chk("busy_at_done", 32'(busy), 32'd1);
        in_frame = 1'b0;
        bus.req_valid = bus.req_valid & ~bus.grant;
      end
      prev_en = bus.tx_enable_signal;
    end
  end

  function automatic int pick(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic exp_frame(input int i);
    logic [7:0] s;
    s = 8'(i) + 8'(pay[i].size());
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(i));
    exp_q.push_back(8'(pay[i].size()));
    for (int k = 0; k < pay[i].size(); k++) begin
      exp_q.push_back(pay[i][k]);
      s = s + pay[i][k];
    end
`ifdef TX_FRAME_CHECKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic fill(input int i, input int len);
    pay[i].delete();
    for (int k = 0; k < len; k++) pay[i].push_back(8'($urandom));
  endtask

  task automatic wait_fd(input int target, input int budget);
    int c = 0;
    while (fd_cnt < target && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  // Offer frames from every requester in mask at once and check the whole exchange.
  task automatic run_frames(input logic [N-1:0] mask, input bit poke_len, input int budget);
    logic [N-1:0] left;
    logic [N-1:0] exp_g [$];
    int           exp_pops [N];
    int           w, base, tot;
    got_q.delete(); exp_q.delete(); gnt_log.delete();
    left = mask; base = fd_cnt; tot = 0;
    for (int i = 0; i < N; i++) begin
      pops[i]     = 0;
      exp_pops[i] = mask[i] ? pay[i].size() : 0;
    end
    while (left != '0) begin
      w = pick(model_ptr, left);
      exp_frame(w);
      tot += FRAME_OVERHEAD + pay[w].size();
      exp_g.push_back(N'(1) << w);
      left[w]   = 1'b0;
      model_ptr = (w + 1) % N;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (mask[i]) begin
        idx[i]         = 0;
        bus.req_len[i] = 8'(pay[i].size());
        bus.req_data[i] = (pay[i].size() > 0) ? pay[i][0] : 8'h00;
      end
    bus.req_valid = mask;
    if (poke_len) begin
      repeat (3) @(negedge clk);
      bus.req_len[0] = 8'h07;   // must not affect the frame already in arbitration
    end
    wait_fd(base + $countones(mask), budget);
    repeat (3) @(negedge clk);
    chk("frame_done_count", 32'(fd_cnt), 32'(base + $countones(mask)));
    chk("byte_count", 32'(got_q.size()), 32'(tot));
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("byte%0d", k), (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD, 32'(exp_q[k]));
    for (int k = 0; k < exp_g.size(); k++)
      chk($sformatf("grant_order%0d", k), (k < gnt_log.size()) ? 32'(gnt_log[k]) : 32'hDEAD, 32'(exp_g[k]));
    for (int i = 0; i < N; i++)
      chk($sformatf("ready_pulses%0d", i), 32'(pops[i]), 32'(exp_pops[i]));
    chk("idle_after", 32'({busy, bus.grant, bus.tx_enable_signal}), 32'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.req_data  = '0;
    bus.tx_done_signal = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx[i]  = 0;
      pops[i] = 0;
    end
    #1;
    chk("reset_outputs", 32'({bus.tx_enable_signal, bus.tx_data, bus.grant, busy, frame_done,
                              bus.req_data_ready}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // both requesters from reset: 0 then 1, twice
    fill(0, 2); fill(1, 3);
    run_frames(2'b11, 1'b0, 600);
    fill(0, 4); fill(1, 1);
    run_frames(2'b11, 1'b0, 600);

    // single frame with known bytes; LEN poke after arbitration is ignored
    pay[0].delete();
    pay[0].push_back(8'h11); pay[0].push_back(8'h22); pay[0].push_back(8'h33);
    run_frames(2'b01, 1'b1, 400);

    // empty payload from requester 1
    pay[1].delete();
    run_frames(2'b10, 1'b0, 400);

    // random masks and lengths with stray done pulses between bytes
    stray_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      fill(0, $urandom_range(0, 6));
      fill(1, $urandom_range(0, 6));
      run_frames(2'($urandom_range(1, 3)), 1'b0, 900);
    end
    stray_en = 1'b0;

    // reset in the middle of payload byte 2
    fill(0, 5);
    for (int i = 0; i < N; i++) pops[i] = 0;
    @(negedge clk);
    idx[0] = 0;
    bus.req_len[0]  = 8'd5;
    bus.req_data[0] = pay[0][0];
    bus.req_valid   = 2'b01;
    for (int c = 0; c < 300 && pops[0] < 2; c++) @(negedge clk);
    chk("reached_pay_byte2", 32'(pops[0]), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("midframe_reset_outputs", 32'({bus.tx_enable_signal, bus.tx_data, bus.grant, busy, frame_done,
                                       bus.req_data_ready}), 32'd0);
    repeat (2) @(negedge clk);
    model_ptr = 0;
    rst = 1'b1;
    run_frames(2'b01, 1'b0, 600);

    // longest payload: 0..254
    pay[0].delete();
    for (int k = 0; k < 255; k++) pay[0].push_back(8'(k));
    run_frames(2'b01, 1'b0, 5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
